// File: rtl/cu_rr_allocator_pkg.sv
// Shared constants, FSM state encoding and arbitration modes for the CU allocator.
package cu_rr_allocator_pkg;

    localparam int DEF_WG_ID_WIDTH       = 8;
    localparam int DEF_NUMBER_CU         = 4;
    localparam int DEF_CU_ID_WIDTH       = 2;
    localparam int DEF_VGPR_ID_WIDTH     = 8;
    localparam int DEF_NUMBER_VGPR_SLOTS = 256;
    localparam int DEF_SGPR_ID_WIDTH     = 8;
    localparam int DEF_NUMBER_SGPR_SLOTS = 256;
    localparam int DEF_LDS_ID_WIDTH      = 7;
    localparam int DEF_NUMBER_LDS_SLOTS  = 128;
    localparam int DEF_GDS_ID_WIDTH      = 7;
    localparam int DEF_GDS_SIZE          = 128;
    localparam int DEF_WG_SLOT_ID_WIDTH  = 6;
    localparam int DEF_NUMBER_WF_SLOTS   = 40;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DECIDE = 2'd2,
        ST_GRANT  = 2'd3
    } alloc_state_t;

endpackage

// File: rtl/cu_rr_allocator_picker.sv
// Combinational first-set search starting at ptr and wrapping at NUMBER_CU-1.
module rr_priority_picker #(
    parameter int NUMBER_CU   = 4,
    parameter int CU_ID_WIDTH = 2
) (
    input  logic [NUMBER_CU-1:0]   cand,
    input  logic [CU_ID_WIDTH-1:0] ptr,
    output logic                   found,
    output logic [CU_ID_WIDTH-1:0] idx
);

    int                   pos;
    logic [CU_ID_WIDTH-1:0] sel;

    // Scan from the farthest offset down so the nearest candidate to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        sel   = '0;
        for (int k = NUMBER_CU - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUMBER_CU) begin
                pos = pos - NUMBER_CU;
            end
            sel = CU_ID_WIDTH'(pos);
            if (cand[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
    end

endmodule

// File: rtl/cu_rr_allocator.sv
// Workgroup-to-CU allocator: parallel fit search over a per-CU free-resource table,
// fixed-priority or round-robin arbitration, grant held until acknowledged.
module cu_rr_allocator
    import cu_rr_allocator_pkg::*;
#(
    parameter int WG_ID_WIDTH       = DEF_WG_ID_WIDTH,
    parameter int NUMBER_CU         = DEF_NUMBER_CU,
    parameter int CU_ID_WIDTH       = DEF_CU_ID_WIDTH,
    parameter int VGPR_ID_WIDTH     = DEF_VGPR_ID_WIDTH,
    parameter int NUMBER_VGPR_SLOTS = DEF_NUMBER_VGPR_SLOTS,
    parameter int SGPR_ID_WIDTH     = DEF_SGPR_ID_WIDTH,
    parameter int NUMBER_SGPR_SLOTS = DEF_NUMBER_SGPR_SLOTS,
    parameter int LDS_ID_WIDTH      = DEF_LDS_ID_WIDTH,
    parameter int NUMBER_LDS_SLOTS  = DEF_NUMBER_LDS_SLOTS,
    parameter int GDS_ID_WIDTH      = DEF_GDS_ID_WIDTH,
    parameter int GDS_SIZE          = DEF_GDS_SIZE,
    parameter int WG_SLOT_ID_WIDTH  = DEF_WG_SLOT_ID_WIDTH,
    parameter int NUMBER_WF_SLOTS   = DEF_NUMBER_WF_SLOTS,
    parameter int ARB_MODE          = ARB_RR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dis_controller_start_alloc,
    input  logic [WG_ID_WIDTH-1:0]     inflight_wg_buffer_alloc_wg_id,
    input  logic [WG_SLOT_ID_WIDTH:0]  inflight_wg_buffer_alloc_num_wf,
    input  logic [VGPR_ID_WIDTH:0]     inflight_wg_buffer_alloc_vgpr_size,
    input  logic [SGPR_ID_WIDTH:0]     inflight_wg_buffer_alloc_sgpr_size,
    input  logic [LDS_ID_WIDTH:0]      inflight_wg_buffer_alloc_lds_size,
    input  logic [GDS_ID_WIDTH:0]      inflight_wg_buffer_alloc_gds_size,
    input  logic [NUMBER_CU-1:0]       dis_controller_cu_busy,
    input  logic                       dis_controller_alloc_ack,
    input  logic                       grt_cam_up_valid,
    input  logic [CU_ID_WIDTH-1:0]     grt_cam_up_cu_id,
    input  logic [VGPR_ID_WIDTH-1:0]   grt_cam_up_vgpr_strt,
    input  logic [VGPR_ID_WIDTH:0]     grt_cam_up_vgpr_size,
    input  logic [SGPR_ID_WIDTH-1:0]   grt_cam_up_sgpr_strt,
    input  logic [SGPR_ID_WIDTH:0]     grt_cam_up_sgpr_size,
    input  logic [LDS_ID_WIDTH-1:0]    grt_cam_up_lds_strt,
    input  logic [LDS_ID_WIDTH:0]      grt_cam_up_lds_size,
    input  logic [GDS_ID_WIDTH-1:0]    grt_cam_up_gds_strt,
    input  logic [GDS_ID_WIDTH:0]      grt_cam_up_gds_size,
    input  logic [WG_SLOT_ID_WIDTH:0]  grt_cam_up_wg_count,
    output logic                       allocator_cu_valid,
    output logic                       allocator_cu_rejected,
    output logic [WG_ID_WIDTH-1:0]     allocator_wg_id_out,
    output logic [CU_ID_WIDTH-1:0]     allocator_cu_id_out,
    output logic [VGPR_ID_WIDTH-1:0]   allocator_vgpr_start_out,
    output logic [VGPR_ID_WIDTH:0]     allocator_vgpr_size_out,
    output logic [SGPR_ID_WIDTH-1:0]   allocator_sgpr_start_out,
    output logic [SGPR_ID_WIDTH:0]     allocator_sgpr_size_out,
    output logic [LDS_ID_WIDTH-1:0]    allocator_lds_start_out,
    output logic [LDS_ID_WIDTH:0]      allocator_lds_size_out,
    output logic [GDS_ID_WIDTH-1:0]    allocator_gds_start_out,
    output logic [GDS_ID_WIDTH:0]      allocator_gds_size_out
);

    alloc_state_t state_reg, state_next;

    logic [WG_SLOT_ID_WIDTH:0] wf_free_reg   [NUMBER_CU];
    logic [VGPR_ID_WIDTH-1:0]  vgpr_strt_reg [NUMBER_CU];
    logic [VGPR_ID_WIDTH:0]    vgpr_size_reg [NUMBER_CU];
    logic [SGPR_ID_WIDTH-1:0]  sgpr_strt_reg [NUMBER_CU];
    logic [SGPR_ID_WIDTH:0]    sgpr_size_reg [NUMBER_CU];
    logic [LDS_ID_WIDTH-1:0]   lds_strt_reg  [NUMBER_CU];
    logic [LDS_ID_WIDTH:0]     lds_size_reg  [NUMBER_CU];
    logic [GDS_ID_WIDTH-1:0]   gds_strt_reg;
    logic [GDS_ID_WIDTH:0]     gds_size_reg;

    // Start values frozen during SEARCH so a concurrent grt write cannot skew the winner's grant.
    logic [VGPR_ID_WIDTH-1:0]  snap_vgpr_strt_reg [NUMBER_CU];
    logic [SGPR_ID_WIDTH-1:0]  snap_sgpr_strt_reg [NUMBER_CU];
    logic [LDS_ID_WIDTH-1:0]   snap_lds_strt_reg  [NUMBER_CU];
    logic [GDS_ID_WIDTH-1:0]   snap_gds_strt_reg;

    logic [WG_ID_WIDTH-1:0]    req_wg_id_reg;
    logic [WG_SLOT_ID_WIDTH:0] req_num_wf_reg;
    logic [VGPR_ID_WIDTH:0]    req_vgpr_size_reg;
    logic [SGPR_ID_WIDTH:0]    req_sgpr_size_reg;
    logic [LDS_ID_WIDTH:0]     req_lds_size_reg;
    logic [GDS_ID_WIDTH:0]     req_gds_size_reg;

    logic [NUMBER_CU-1:0]      cand_next, cand_reg;
    logic [CU_ID_WIDTH-1:0]    rr_ptr_reg, pick_ptr, pick_idx;
    logic                      pick_found;

    logic                      valid_reg, rejected_reg;
    logic [WG_ID_WIDTH-1:0]    wg_id_out_reg;
    logic [CU_ID_WIDTH-1:0]    cu_id_out_reg;
    logic [VGPR_ID_WIDTH-1:0]  vgpr_start_out_reg;
    logic [VGPR_ID_WIDTH:0]    vgpr_size_out_reg;
    logic [SGPR_ID_WIDTH-1:0]  sgpr_start_out_reg;
    logic [SGPR_ID_WIDTH:0]    sgpr_size_out_reg;
    logic [LDS_ID_WIDTH-1:0]   lds_start_out_reg;
    logic [LDS_ID_WIDTH:0]     lds_size_out_reg;
    logic [GDS_ID_WIDTH-1:0]   gds_start_out_reg;
    logic [GDS_ID_WIDTH:0]     gds_size_out_reg;

    generate
        for (genvar gi = 0; gi < NUMBER_CU; gi++) begin : g_cu
            always_ff @(posedge clk) begin
                if (rst) begin
                    wf_free_reg[gi]   <= (WG_SLOT_ID_WIDTH+1)'(NUMBER_WF_SLOTS);
                    vgpr_strt_reg[gi] <= '0;
                    vgpr_size_reg[gi] <= (VGPR_ID_WIDTH+1)'(NUMBER_VGPR_SLOTS);
                    sgpr_strt_reg[gi] <= '0;
                    sgpr_size_reg[gi] <= (SGPR_ID_WIDTH+1)'(NUMBER_SGPR_SLOTS);
                    lds_strt_reg[gi]  <= '0;
                    lds_size_reg[gi]  <= (LDS_ID_WIDTH+1)'(NUMBER_LDS_SLOTS);
                end else if (grt_cam_up_valid && grt_cam_up_cu_id == CU_ID_WIDTH'(gi)) begin
                    wf_free_reg[gi]   <= grt_cam_up_wg_count;
                    vgpr_strt_reg[gi] <= grt_cam_up_vgpr_strt;
                    vgpr_size_reg[gi] <= grt_cam_up_vgpr_size;
                    sgpr_strt_reg[gi] <= grt_cam_up_sgpr_strt;
                    sgpr_size_reg[gi] <= grt_cam_up_sgpr_size;
                    lds_strt_reg[gi]  <= grt_cam_up_lds_strt;
                    lds_size_reg[gi]  <= grt_cam_up_lds_size;
                end
            end

            always_ff @(posedge clk) begin
                if (state_reg == ST_SEARCH) begin
                    snap_vgpr_strt_reg[gi] <= vgpr_strt_reg[gi];
                    snap_sgpr_strt_reg[gi] <= sgpr_strt_reg[gi];
                    snap_lds_strt_reg[gi]  <= lds_strt_reg[gi];
                end
            end

            assign cand_next[gi] = !dis_controller_cu_busy[gi]
                                && (wf_free_reg[gi]   >= req_num_wf_reg)
                                && (vgpr_size_reg[gi] >= req_vgpr_size_reg)
                                && (sgpr_size_reg[gi] >= req_sgpr_size_reg)
                                && (lds_size_reg[gi]  >= req_lds_size_reg)
                                && (gds_size_reg      >= req_gds_size_reg);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            gds_strt_reg <= '0;
            gds_size_reg <= (GDS_ID_WIDTH+1)'(GDS_SIZE);
        end else if (grt_cam_up_valid) begin
            gds_strt_reg <= grt_cam_up_gds_strt;
            gds_size_reg <= grt_cam_up_gds_size;
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_SEARCH) begin
            snap_gds_strt_reg <= gds_strt_reg;
        end
    end

    assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_reg : '0;

    rr_priority_picker #(
        .NUMBER_CU   (NUMBER_CU),
        .CU_ID_WIDTH (CU_ID_WIDTH)
    ) u_picker (
        .cand  (cand_reg),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (dis_controller_start_alloc) state_next = ST_SEARCH;
            ST_SEARCH: state_next = ST_DECIDE;
            ST_DECIDE: state_next = pick_found ? ST_GRANT : ST_IDLE;
            ST_GRANT:  if (dis_controller_alloc_ack) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            rr_ptr_reg         <= '0;
            cand_reg           <= '0;
            req_wg_id_reg      <= '0;
            req_num_wf_reg     <= '0;
            req_vgpr_size_reg  <= '0;
            req_sgpr_size_reg  <= '0;
            req_lds_size_reg   <= '0;
            req_gds_size_reg   <= '0;
            valid_reg          <= 1'b0;
            rejected_reg       <= 1'b0;
            wg_id_out_reg      <= '0;
            cu_id_out_reg      <= '0;
            vgpr_start_out_reg <= '0;
            vgpr_size_out_reg  <= '0;
            sgpr_start_out_reg <= '0;
            sgpr_size_out_reg  <= '0;
            lds_start_out_reg  <= '0;
            lds_size_out_reg   <= '0;
            gds_start_out_reg  <= '0;
            gds_size_out_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            rejected_reg <= (state_reg == ST_DECIDE) && !pick_found;
            if (state_reg == ST_IDLE && dis_controller_start_alloc) begin
                req_wg_id_reg     <= inflight_wg_buffer_alloc_wg_id;
                req_num_wf_reg    <= inflight_wg_buffer_alloc_num_wf;
                req_vgpr_size_reg <= inflight_wg_buffer_alloc_vgpr_size;
                req_sgpr_size_reg <= inflight_wg_buffer_alloc_sgpr_size;
                req_lds_size_reg  <= inflight_wg_buffer_alloc_lds_size;
                req_gds_size_reg  <= inflight_wg_buffer_alloc_gds_size;
            end
            if (state_reg == ST_SEARCH) begin
                cand_reg <= cand_next;
            end
            if (state_reg == ST_DECIDE && pick_found) begin
                valid_reg          <= 1'b1;
                cu_id_out_reg      <= pick_idx;
                wg_id_out_reg      <= req_wg_id_reg;
                vgpr_start_out_reg <= snap_vgpr_strt_reg[pick_idx];
                sgpr_start_out_reg <= snap_sgpr_strt_reg[pick_idx];
                lds_start_out_reg  <= snap_lds_strt_reg[pick_idx];
                gds_start_out_reg  <= snap_gds_strt_reg;
                vgpr_size_out_reg  <= req_vgpr_size_reg;
                sgpr_size_out_reg  <= req_sgpr_size_reg;
                lds_size_out_reg   <= req_lds_size_reg;
                gds_size_out_reg   <= req_gds_size_reg;
            end
            if (state_reg == ST_GRANT && dis_controller_alloc_ack) begin
                valid_reg  <= 1'b0;
                rr_ptr_reg <= (cu_id_out_reg == CU_ID_WIDTH'(NUMBER_CU - 1))
                              ? '0 : cu_id_out_reg + CU_ID_WIDTH'(1);
            end
        end
    end

    assign allocator_cu_valid       = valid_reg;
    assign allocator_cu_rejected    = rejected_reg;
    assign allocator_wg_id_out      = wg_id_out_reg;
    assign allocator_cu_id_out      = cu_id_out_reg;
    assign allocator_vgpr_start_out = vgpr_start_out_reg;
    assign allocator_vgpr_size_out  = vgpr_size_out_reg;
    assign allocator_sgpr_start_out = sgpr_start_out_reg;
    assign allocator_sgpr_size_out  = sgpr_size_out_reg;
    assign allocator_lds_start_out  = lds_start_out_reg;
    assign allocator_lds_size_out   = lds_size_out_reg;
    assign allocator_gds_start_out  = gds_start_out_reg;
    assign allocator_gds_size_out   = gds_size_out_reg;

endmodule

// File: tb/tb_cu_rr_allocator.sv
// Directed bench: a round-robin and a fixed-priority allocator share one stimulus stream.
module tb_cu_rr_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] wg_id;
    logic [6:0] num_wf;
    logic [8:0] vgpr_size, sgpr_size;
    logic [7:0] lds_size, gds_size;
    logic [3:0] busy;
    logic       ack;
    logic       up_valid;
    logic [1:0] up_cu;
    logic [7:0] up_vgpr_strt, up_sgpr_strt;
    logic [8:0] up_vgpr_size, up_sgpr_size;
    logic [6:0] up_lds_strt, up_gds_strt;
    logic [7:0] up_lds_size, up_gds_size;
    logic [6:0] up_wg_count;

    logic       r_valid, r_rej, f_valid, f_rej;
    logic [7:0] r_wg, f_wg;
    logic [1:0] r_cu, f_cu;
    logic [7:0] r_vs, r_ss, f_vs, f_ss;
    logic [8:0] r_vz, r_sz, f_vz, f_sz;
    logic [6:0] r_ls, r_gs, f_ls, f_gs;
    logic [7:0] r_lz, r_gz, f_lz, f_gz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cu_rr_allocator #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .dis_controller_start_alloc(start),
        .inflight_wg_buffer_alloc_wg_id(wg_id),
        .inflight_wg_buffer_alloc_num_wf(num_wf),
        .inflight_wg_buffer_alloc_vgpr_size(vgpr_size),
        .inflight_wg_buffer_alloc_sgpr_size(sgpr_size),
        .inflight_wg_buffer_alloc_lds_size(lds_size),
        .inflight_wg_buffer_alloc_gds_size(gds_size),
        .dis_controller_cu_busy(busy),
        .dis_controller_alloc_ack(ack),
        .grt_cam_up_valid(up_valid), .grt_cam_up_cu_id(up_cu),
        .grt_cam_up_vgpr_strt(up_vgpr_strt), .grt_cam_up_vgpr_size(up_vgpr_size),
        .grt_cam_up_sgpr_strt(up_sgpr_strt), .grt_cam_up_sgpr_size(up_sgpr_size),
        .grt_cam_up_lds_strt(up_lds_strt), .grt_cam_up_lds_size(up_lds_size),
        .grt_cam_up_gds_strt(up_gds_strt), .grt_cam_up_gds_size(up_gds_size),
        .grt_cam_up_wg_count(up_wg_count),
        .allocator_cu_valid(r_valid), .allocator_cu_rejected(r_rej),
        .allocator_wg_id_out(r_wg), .allocator_cu_id_out(r_cu),
        .allocator_vgpr_start_out(r_vs), .allocator_vgpr_size_out(r_vz),
        .allocator_sgpr_start_out(r_ss), .allocator_sgpr_size_out(r_sz),
        .allocator_lds_start_out(r_ls), .allocator_lds_size_out(r_lz),
        .allocator_gds_start_out(r_gs), .allocator_gds_size_out(r_gz)
    );

    cu_rr_allocator #(.ARB_MODE(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .dis_controller_start_alloc(start),
        .inflight_wg_buffer_alloc_wg_id(wg_id),
        .inflight_wg_buffer_alloc_num_wf(num_wf),
        .inflight_wg_buffer_alloc_vgpr_size(vgpr_size),
        .inflight_wg_buffer_alloc_sgpr_size(sgpr_size),
        .inflight_wg_buffer_alloc_lds_size(lds_size),
        .inflight_wg_buffer_alloc_gds_size(gds_size),
        .dis_controller_cu_busy(busy),
        .dis_controller_alloc_ack(ack),
        .grt_cam_up_valid(up_valid), .grt_cam_up_cu_id(up_cu),
        .grt_cam_up_vgpr_strt(up_vgpr_strt), .grt_cam_up_vgpr_size(up_vgpr_size),
        .grt_cam_up_sgpr_strt(up_sgpr_strt), .grt_cam_up_sgpr_size(up_sgpr_size),
        .grt_cam_up_lds_strt(up_lds_strt), .grt_cam_up_lds_size(up_lds_size),
        .grt_cam_up_gds_strt(up_gds_strt), .grt_cam_up_gds_size(up_gds_size),
        .grt_cam_up_wg_count(up_wg_count),
        .allocator_cu_valid(f_valid), .allocator_cu_rejected(f_rej),
        .allocator_wg_id_out(f_wg), .allocator_cu_id_out(f_cu),
        .allocator_vgpr_start_out(f_vs), .allocator_vgpr_size_out(f_vz),
        .allocator_sgpr_start_out(f_ss), .allocator_sgpr_size_out(f_sz),
        .allocator_lds_start_out(f_ls), .allocator_lds_size_out(f_lz),
        .allocator_gds_start_out(f_gs), .allocator_gds_size_out(f_gz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start in cycle 0 and returns in cycle 3, where valid or rejected is due.
    task automatic request(input logic [7:0] id, input logic [6:0] nwf, input logic [8:0] v,
                           input logic [8:0] s, input logic [7:0] l, input logic [7:0] g);
        start = 1'b1; wg_id = id; num_wf = nwf;
        vgpr_size = v; sgpr_size = s; lds_size = l; gds_size = g;
        tick();
        start = 1'b0;
        tick();
        check("decide_no_valid", {31'd0, r_valid}, 32'd0);
        tick();
        $display("request wg=%0h vgpr=%0d gds=%0d -> rr valid=%0b rej=%0b cu=%0d | fixed valid=%0b cu=%0d",
                 id, v, g, r_valid, r_rej, r_cu, f_valid, f_cu);
    endtask

    task automatic cam_up(input logic [1:0] cu, input logic [7:0] vstrt, input logic [8:0] vsize,
                          input logic [6:0] gstrt, input logic [7:0] gsize);
        up_valid = 1'b1; up_cu = cu;
        up_vgpr_strt = vstrt; up_vgpr_size = vsize;
        up_sgpr_strt = 8'd0;  up_sgpr_size = 9'd256;
        up_lds_strt  = 7'd0;  up_lds_size  = 8'd128;
        up_gds_strt  = gstrt; up_gds_size  = gsize;
        up_wg_count  = 7'd40;
        tick();
        up_valid = 1'b0;
        $display("cam_up cu=%0d vgpr=%0d/%0d gds=%0d/%0d", cu, vstrt, vsize, gstrt, gsize);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_drop_rr", {31'd0, r_valid}, 32'd0);
        check("ack_drop_fixed", {31'd0, f_valid}, 32'd0);
        $display("ack -> rr valid=%0b fixed valid=%0b", r_valid, f_valid);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wg_id = '0; num_wf = '0;
        vgpr_size = '0; sgpr_size = '0; lds_size = '0; gds_size = '0;
        busy = '0; ack = 1'b0; up_valid = 1'b0; up_cu = '0;
        up_vgpr_strt = '0; up_vgpr_size = '0; up_sgpr_strt = '0; up_sgpr_size = '0;
        up_lds_strt = '0; up_lds_size = '0; up_gds_strt = '0; up_gds_size = '0;
        up_wg_count = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, r_valid}, 32'd0);
        check("rst_rej", {31'd0, r_rej}, 32'd0);
        check("rst_cu", {30'd0, r_cu}, 32'd0);
        check("rst_vstart", {24'd0, r_vs}, 32'd0);
        check("rst_vsize", {23'd0, r_vz}, 32'd0);
        check("rst_fixed_valid", {31'd0, f_valid}, 32'd0);
        $display("reset released");

        // First grant on an empty table
        request(8'h11, 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
        check("g1_valid", {31'd0, r_valid}, 32'd1);
        check("g1_cu", {30'd0, r_cu}, 32'd0);
        check("g1_wg", {24'd0, r_wg}, 32'h11);
        check("g1_vstart", {24'd0, r_vs}, 32'd0);
        check("g1_sstart", {24'd0, r_ss}, 32'd0);
        check("g1_lstart", {25'd0, r_ls}, 32'd0);
        check("g1_gstart", {25'd0, r_gs}, 32'd0);
        check("g1_vsize", {23'd0, r_vz}, 32'd32);
        check("g1_ssize", {23'd0, r_sz}, 32'd16);
        check("g1_lsize", {24'd0, r_lz}, 32'd8);
        check("g1_gsize", {24'd0, r_gz}, 32'd8);
        check("g1_fixed_cu", {30'd0, f_cu}, 32'd0);
        tick();
        check("g1_hold_valid", {31'd0, r_valid}, 32'd1);
        check("g1_hold_wg", {24'd0, r_wg}, 32'h11);
        do_ack();

        // Round-robin rotation 1,2,3 then wrap to 0; fixed priority stays on 0
        for (int i = 1; i <= 4; i++) begin
            request(8'h20 + 8'(i), 7'd2, 9'd32, 9'd16, 8'd8, 8'd8);
            check("rr_valid", {31'd0, r_valid}, 32'd1);
            check("rr_cu", {30'd0, r_cu}, 32'(i % 4));
            check("fixed_valid", {31'd0, f_valid}, 32'd1);
            check("fixed_cu", {30'd0, f_cu}, 32'd0);
            do_ack();
        end

        // Full-size VGPR request fits only an untouched entry
        request(8'h30, 7'd1, 9'd256, 9'd0, 8'd0, 8'd0);
        check("full_valid", {31'd0, r_valid}, 32'd1);
        check("full_cu", {30'd0, r_cu}, 32'd1);
        check("full_vsize", {23'd0, r_vz}, 32'd256);
        do_ack();
        for (int c = 0; c < 4; c++) cam_up(2'(c), 8'd0, 9'd224, 7'd0, 8'd128);
        request(8'h31, 7'd1, 9'd256, 9'd0, 8'd0, 8'd0);
        check("full_rej", {31'd0, r_rej}, 32'd1);
        check("full_rej_novalid", {31'd0, r_valid}, 32'd0);
        check("full_rej_fixed", {31'd0, f_rej}, 32'd1);
        tick();
        check("rej_one_cycle", {31'd0, r_rej}, 32'd0);
        check("rej_still_novalid", {31'd0, r_valid}, 32'd0);

        // Busy CUs excluded; the only fit carries its updated start
        busy = 4'b0111;
        cam_up(2'd3, 8'd32, 9'd224, 7'd0, 8'd128);
        request(8'h32, 7'd1, 9'd32, 9'd0, 8'd0, 8'd0);
        check("busy_valid", {31'd0, r_valid}, 32'd1);
        check("busy_cu", {30'd0, r_cu}, 32'd3);
        check("busy_vstart", {24'd0, r_vs}, 32'd32);
        check("busy_fixed_cu", {30'd0, f_cu}, 32'd3);
        busy = 4'b0000;
        do_ack();

        // Global GDS entry gates every CU
        cam_up(2'd0, 8'd0, 9'd224, 7'd0, 8'd4);
        request(8'h33, 7'd1, 9'd0, 9'd0, 8'd0, 8'd8);
        check("gds_rej", {31'd0, r_rej}, 32'd1);
        check("gds_rej_novalid", {31'd0, r_valid}, 32'd0);
        tick();
        cam_up(2'd0, 8'd0, 9'd224, 7'd16, 8'd8);
        request(8'h34, 7'd1, 9'd0, 9'd0, 8'd0, 8'd8);
        check("gds_valid", {31'd0, r_valid}, 32'd1);
        check("gds_cu", {30'd0, r_cu}, 32'd0);
        check("gds_gstart", {25'd0, r_gs}, 32'd16);
        check("gds_gsize", {24'd0, r_gz}, 32'd8);

        // Reset during GRANT aborts the grant and restores the table
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("grant_rst_valid", {31'd0, r_valid}, 32'd0);
        check("grant_rst_rej", {31'd0, r_rej}, 32'd0);
        check("grant_rst_cu", {30'd0, r_cu}, 32'd0);
        $display("reset during grant");

        // start held into SEARCH must not launch a second request
        start = 1'b1; wg_id = 8'h40; num_wf = 7'd1;
        vgpr_size = 9'd256; sgpr_size = 9'd0; lds_size = 8'd0; gds_size = 8'd128;
        tick();
        wg_id = 8'h41;
        tick();
        start = 1'b0;
        tick();
        check("restored_valid", {31'd0, r_valid}, 32'd1);
        check("restored_cu", {30'd0, r_cu}, 32'd0);
        check("restored_wg", {24'd0, r_wg}, 32'h40);
        check("restored_gstart", {25'd0, r_gs}, 32'd0);
        $display("post-reset request -> valid=%0b cu=%0d wg=%0h", r_valid, r_cu, r_wg);
        do_ack();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_extra_valid", {31'd0, r_valid}, 32'd0);
            check("no_extra_rej", {31'd0, r_rej}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
